// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the CPU: machine word, fetch-stage state encoding and PC reset value.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    HALTED   = 2'd2
  } fetch_state_t;

  localparam word_t PC_RESET = 32'h0000_0000;

  // Sequential successor; wraps modulo 2^32.
  function automatic word_t pc_plus4(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifid_latch.sv
// IF/ID pipeline register: flush clears to a bubble and takes priority over enable.
module ifid_latch
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  flush,
  input  word_t nxt_instr,
  input  word_t nxt_pcplus4,
  input  logic  nxt_valid,
  output word_t instr,
  output word_t pcplus4,
  output logic  valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr   <= '0;
      pcplus4 <= '0;
      valid   <= 1'b0;
    end else if (flush) begin
      instr   <= '0;
      pcplus4 <= '0;
      valid   <= 1'b0;
    end else if (en) begin
      instr   <= nxt_instr;
      pcplus4 <= nxt_pcplus4;
      valid   <= nxt_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, icache request, halt latch, IF/ID load.
// Define FETCH_IBUF_EN to add a one-entry buffer that holds a returned word while IF/ID is stalled.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = PC_RESET
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  pc_en,
  input  logic  if_en,
  input  logic  if_flush,
  input  logic  iren_in,
  input  logic  pr_halt,
  input  logic  pcsrc,
  input  word_t branch_target,
  input  logic  id_jr,
  input  word_t jr_target,
  input  logic  id_jump,
  input  word_t jump_target,
  input  logic  ihit,
  input  word_t iload,
  output logic  imemREN,
  output word_t imemaddr,
  output word_t ifid_instr,
  output word_t ifid_pcplus4,
  output logic  ifid_valid,
  output logic  halted
);

  fetch_state_t state;
  word_t        pc;
  word_t        pcplus4;
  word_t        next_pc;
  word_t        fetch_word;
  logic         fetch_hit;

  assign pcplus4 = pc_plus4(pc);

  // MEM branch outranks ID redirects: it resolves an older instruction.
  always_comb begin
    if (pcsrc) begin
      next_pc = branch_target;
    end else if (id_jr) begin
      next_pc = jr_target;
    end else if (id_jump) begin
      next_pc = jump_target;
    end else begin
      next_pc = pcplus4;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc <= PC_INIT;
    end else if (pc_en && (state != HALTED)) begin
      pc <= next_pc;
    end
  end

  assign imemaddr = pc;
  assign imemREN  = iren_in & (state == FETCH);
  assign halted   = (state == HALTED);

`ifdef FETCH_IBUF_EN
  word_t ibuf;
  logic  redirect;
  logic  capture;

  assign redirect = pcsrc | id_jr | id_jump;
  // Park a returned word only if IF/ID cannot take it and it is not about to be discarded.
  assign capture  = ihit & ~if_en & ~if_flush & ~redirect;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FETCH;
      ibuf  <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (pr_halt) begin
            state <= HALTED;
          end else if (capture) begin
            ibuf  <= iload;
            state <= BUFFERED;
          end
        end
        BUFFERED: begin
          if (pr_halt) begin
            state <= HALTED;
          end else if (if_flush || redirect || if_en) begin
            state <= FETCH;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  assign fetch_word = (state == BUFFERED) ? ibuf : iload;
  assign fetch_hit  = (state == BUFFERED) ? 1'b1 : ihit;
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (pr_halt) begin
            state <= HALTED;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // Without a buffer a stalled fetch simply stays requested at the same PC.
  assign fetch_word = iload;
  assign fetch_hit  = ihit;
`endif

  ifid_latch u_ifid_latch (
    .clk         (CLK),
    .rst         (RST),
    .en          (if_en),
    .flush       (if_flush),
    .nxt_instr   (fetch_word),
    .nxt_pcplus4 (pcplus4),
    .nxt_valid   (fetch_hit),
    .instr       (ifid_instr),
    .pcplus4     (ifid_pcplus4),
    .valid       (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle-level reference model plus hand-computed spot values.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST;
  logic  pc_en, if_en, if_flush, iren_in, pr_halt;
  logic  pcsrc, id_jr, id_jump, ihit;
  word_t branch_target, jr_target, jump_target, iload;
  logic  imemREN, ifid_valid, halted;
  word_t imemaddr, ifid_instr, ifid_pcplus4;

  logic  iload_ovr_en;
  word_t iload_ovr;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  // Instruction memory stand-in: word content derived from the requested address.
  assign iload = iload_ovr_en ? iload_ovr : (imemaddr ^ 32'h1234_5678);

  fetch_stage dut (
    .CLK           (CLK),
    .RST           (RST),
    .pc_en         (pc_en),
    .if_en         (if_en),
    .if_flush      (if_flush),
    .iren_in       (iren_in),
    .pr_halt       (pr_halt),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .id_jr         (id_jr),
    .jr_target     (jr_target),
    .id_jump       (id_jump),
    .jump_target   (jump_target),
    .ihit          (ihit),
    .iload         (iload),
    .imemREN       (imemREN),
    .imemaddr      (imemaddr),
    .ifid_instr    (ifid_instr),
    .ifid_pcplus4  (ifid_pcplus4),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural PC, halt flag, IF/ID contents, parked word (queue of 0/1).
  word_t m_pc, m_instr, m_pcp4, m_w, m_pp4;
  logic  m_halted, m_valid, m_h, m_redir;
  word_t m_buf[$];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pc     = 32'h0;
      m_halted = 1'b0;
      m_instr  = 32'h0;
      m_pcp4   = 32'h0;
      m_valid  = 1'b0;
      m_buf.delete();
    end else begin
      m_redir = pcsrc || id_jr || id_jump;
      m_w     = (m_buf.size() != 0) ? m_buf[0] : iload;
      m_h     = (m_buf.size() != 0) ? 1'b1 : ihit;
      m_pp4   = m_pc + 32'd4;
      if (if_flush) begin
        m_instr = 32'h0;
        m_pcp4  = 32'h0;
        m_valid = 1'b0;
      end else if (if_en) begin
        m_instr = m_w;
        m_pcp4  = m_pp4;
        m_valid = m_h;
      end
`ifdef FETCH_IBUF_EN
      if (m_buf.size() != 0) begin
        if (if_en || if_flush || m_redir || pr_halt) m_buf.delete();
      end else if (!m_halted && !pr_halt && ihit && !if_en && !if_flush && !m_redir) begin
        m_buf.push_back(iload);
      end
`endif
      if (pc_en && !m_halted) begin
        if (pcsrc) m_pc = branch_target;
        else if (id_jr) m_pc = jr_target;
        else if (id_jump) m_pc = jump_target;
        else m_pc = m_pp4;
      end
      if (pr_halt) m_halted = 1'b1;
    end
  end

  always @(negedge CLK) begin
    chk("imemaddr", imemaddr, m_pc);
    chk("imemREN", {31'b0, imemREN}, {31'b0, iren_in && !m_halted && (m_buf.size() == 0)});
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pcplus4", ifid_pcplus4, m_pcp4);
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    chk("halted", {31'b0, halted}, {31'b0, m_halted});
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    pc_en = 1'b1; if_en = 1'b1; if_flush = 1'b0; iren_in = 1'b1; pr_halt = 1'b0;
    pcsrc = 1'b0; id_jr = 1'b0; id_jump = 1'b0; ihit = 1'b1;
    branch_target = '0; jr_target = '0; jump_target = '0;
    iload_ovr_en = 1'b0; iload_ovr = '0;
    #3;
    chk("rst_addr", imemaddr, 32'h0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_ren", {31'b0, imemREN}, 32'h1);
    #9 RST = 1'b0;

    // Sequential stream
    step(); chk("seq_addr4", imemaddr, 32'h4); chk("seq_p4_4", ifid_pcplus4, 32'h4);
    chk("seq_valid", {31'b0, ifid_valid}, 32'h1);
    step(); chk("seq_addr8", imemaddr, 32'h8); chk("seq_p4_8", ifid_pcplus4, 32'h8);
    step(); chk("seq_p4_c", ifid_pcplus4, 32'hC);
    step(); chk("seq_addr10", imemaddr, 32'h10);

    // Miss with PC stalled and IF/ID flushed
    pc_en = 1'b0; ihit = 1'b0; if_flush = 1'b1;
    repeat (3) step();
    chk("miss_addr", imemaddr, 32'h10);
    chk("miss_valid", {31'b0, ifid_valid}, 32'h0);
    chk("miss_ren", {31'b0, imemREN}, 32'h1);
    pc_en = 1'b1; ihit = 1'b1; if_flush = 1'b0;
    step(); chk("hit_instr", ifid_instr, 32'h1234_5668); chk("hit_addr", imemaddr, 32'h14);

    // Branch and jump together: branch wins
    pcsrc = 1'b1; branch_target = 32'h40; id_jump = 1'b1; jump_target = 32'h80; if_flush = 1'b1;
    step(); chk("br_addr", imemaddr, 32'h40); chk("br_flush", {31'b0, ifid_valid}, 32'h0);
    pcsrc = 1'b0; if_flush = 1'b0;

    // JR beats jump; then wrap at the top of the address space
    id_jr = 1'b1; jr_target = 32'h100;
    step(); chk("jr_addr", imemaddr, 32'h100);
    id_jump = 1'b0; jr_target = 32'hFFFF_FFFC;
    step(); chk("jr_top", imemaddr, 32'hFFFF_FFFC);
    id_jr = 1'b0;
    step(); chk("wrap_addr", imemaddr, 32'h0); chk("wrap_p4", ifid_pcplus4, 32'h0);
    chk("wrap_instr", ifid_instr, 32'hEDCB_A984);

    // Halt
    id_jr = 1'b1; jr_target = 32'h20;
    step(); id_jr = 1'b0; pr_halt = 1'b1;
    step(); pr_halt = 1'b0;
    chk("halt_ren", {31'b0, imemREN}, 32'h0); chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_addr", imemaddr, 32'h24);
    pcsrc = 1'b1; branch_target = 32'h300;
    step(); chk("halt_hold", imemaddr, 32'h24);
    pcsrc = 1'b0; if_flush = 1'b1;
    step(); chk("halt_drain", {31'b0, ifid_valid}, 32'h0);
    if_flush = 1'b0;
    #2 RST = 1'b1;
    #1 chk("rst_halt_addr", imemaddr, 32'h0); chk("rst_halt_flag", {31'b0, halted}, 32'h0);
    chk("rst_halt_ren", {31'b0, imemREN}, 32'h1);
    #3 RST = 1'b0;
    step(); chk("post_rst_addr", imemaddr, 32'h4);

    // Reset during an outstanding miss
    ihit = 1'b0; id_jump = 1'b1; jump_target = 32'h500;
    step(); chk("jmp_addr", imemaddr, 32'h500);
    id_jump = 1'b0; pc_en = 1'b0;
    step();
    #2 RST = 1'b1;
    #1 chk("rst_miss_addr", imemaddr, 32'h0);
    #3 RST = 1'b0;
    ihit = 1'b1; pc_en = 1'b1;
    step(); chk("rst_miss_next", imemaddr, 32'h4); chk("rst_miss_p4", ifid_pcplus4, 32'h4);

    // Word returned while IF/ID stalled
    if_en = 1'b0; pc_en = 1'b0; iload_ovr_en = 1'b1; iload_ovr = 32'hDEAD_BEEF;
    step();
`ifdef FETCH_IBUF_EN
    chk("buf_ren", {31'b0, imemREN}, 32'h0);
    iload_ovr = 32'h1111_1111; if_en = 1'b1; pc_en = 1'b1;
    step(); chk("buf_instr", ifid_instr, 32'hDEAD_BEEF); chk("buf_ren_back", {31'b0, imemREN}, 32'h1);
    chk("buf_addr", imemaddr, 32'h8);
    if_en = 1'b0; pc_en = 1'b0; iload_ovr = 32'hCAFE_F00D;
    step(); chk("buf2_ren", {31'b0, imemREN}, 32'h0);
    pcsrc = 1'b1; branch_target = 32'h200; pc_en = 1'b1;
    step(); chk("buf_drop_ren", {31'b0, imemREN}, 32'h1); chk("buf_drop_addr", imemaddr, 32'h200);
    pcsrc = 1'b0; if_en = 1'b1; iload_ovr = 32'h2222_2222;
    step(); chk("buf_drop_instr", ifid_instr, 32'h2222_2222);
`else
    chk("rereq_ren", {31'b0, imemREN}, 32'h1); chk("rereq_addr", imemaddr, 32'h4);
    chk("stall_instr", ifid_instr, 32'h1234_5678);
    if_en = 1'b1; pc_en = 1'b1;
    step(); chk("rereq_instr", ifid_instr, 32'hDEAD_BEEF); chk("rereq_next", imemaddr, 32'h8);
`endif
    iload_ovr_en = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
